// File: rtl/trx_sched.sv
// trx_sched: edge-armed RX/TX window scheduler. Round-robin arbitration, and a fixed
// guard interval ahead of every window.
module trx_sched #(
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ext_counter_value_RX,
    input  logic        ext_counter_flag_RX,
    input  logic [15:0] ext_counter_value_TX,
    input  logic        ext_counter_flag_TX,
    input  logic        abort,
    output logic        rx_en,
    output logic        tx_en,
    output logic        busy,
    output logic        rx_done,
    output logic        tx_done,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GUARD  = 2'd1,
        RX_WIN = 2'd2,
        TX_WIN = 2'd3
    } state_t;

    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES);
    localparam logic       DIR_RX     = 1'b0;
    localparam logic       DIR_TX     = 1'b1;

    state_t      state_r, state_s;
    logic        flag_prev_rx_r, flag_prev_tx_r;
    logic        pend_rx_r, pend_tx_r, pend_rx_s, pend_tx_s;
    logic        overrun_r, overrun_s;
    logic        last_grant_r, grant_r, grant_s;
    logic [15:0] win_len_r, cnt_r;
    logic [7:0]  guard_cnt_r;
    logic        arm_rx_s, arm_tx_s, granting_s, keep_rx_s, keep_tx_s;
    logic        guard_end_s, win_end_s, finish_s;
    logic        rx_en_r, tx_en_r, busy_r, rx_done_r, tx_done_r;
    logic        rx_en_s, tx_en_s, busy_s, rx_done_s, tx_done_s;

    assign guard_end_s = (guard_cnt_r == 8'd1);
    assign win_end_s   = (cnt_r == 16'd1);

    // Edge detection, round-robin grant selection and pending/overrun bookkeeping
    always_comb begin
        arm_rx_s   = ext_counter_flag_RX & ~flag_prev_rx_r;
        arm_tx_s   = ext_counter_flag_TX & ~flag_prev_tx_r;
        granting_s = (state_r == IDLE) && !abort && (pend_rx_r || pend_tx_r);
        if (pend_rx_r && pend_tx_r) begin
            grant_s = ~last_grant_r;
        end else if (pend_tx_r) begin
            grant_s = DIR_TX;
        end else begin
            grant_s = DIR_RX;
        end
        // A grant clears its pending bit first, so a same-cycle arm re-queues cleanly
        keep_rx_s = pend_rx_r & ~(granting_s & (grant_s == DIR_RX));
        keep_tx_s = pend_tx_r & ~(granting_s & (grant_s == DIR_TX));
        if (abort) begin
            pend_rx_s = 1'b0;
            pend_tx_s = 1'b0;
            overrun_s = overrun_r;
        end else begin
            pend_rx_s = keep_rx_s | arm_rx_s;
            pend_tx_s = keep_tx_s | arm_tx_s;
            overrun_s = overrun_r | (arm_rx_s & keep_rx_s) | (arm_tx_s & keep_tx_s);
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pend_rx_r || pend_tx_r) state_s = GUARD;
                    else                        state_s = IDLE;
                end
                GUARD: begin
                    if (!guard_end_s)              state_s = GUARD;
                    else if (win_len_r == 16'd0)   state_s = IDLE;
                    else if (grant_r == DIR_TX)    state_s = TX_WIN;
                    else                           state_s = RX_WIN;
                end
                RX_WIN, TX_WIN: begin
                    if (win_end_s) state_s = IDLE;
                    else           state_s = state_r;
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state; done pulses mark the window's last transition
    always_comb begin
        rx_en_s = (state_s == RX_WIN);
        tx_en_s = (state_s == TX_WIN);
        busy_s  = (state_s != IDLE);
        if (abort) begin
            finish_s = 1'b0;
        end else if ((state_r == GUARD) && guard_end_s && (win_len_r == 16'd0)) begin
            finish_s = 1'b1;
        end else if (((state_r == RX_WIN) || (state_r == TX_WIN)) && win_end_s) begin
            finish_s = 1'b1;
        end else begin
            finish_s = 1'b0;
        end
        rx_done_s = finish_s & (grant_r == DIR_RX);
        tx_done_s = finish_s & (grant_r == DIR_TX);
    end

    // State, flag history, pending bits and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            flag_prev_rx_r <= 1'b0;
            flag_prev_tx_r <= 1'b0;
            pend_rx_r      <= 1'b0;
            pend_tx_r      <= 1'b0;
            overrun_r      <= 1'b0;
            rx_en_r        <= 1'b0;
            tx_en_r        <= 1'b0;
            busy_r         <= 1'b0;
            rx_done_r      <= 1'b0;
            tx_done_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            flag_prev_rx_r <= ext_counter_flag_RX;
            flag_prev_tx_r <= ext_counter_flag_TX;
            pend_rx_r      <= pend_rx_s;
            pend_tx_r      <= pend_tx_s;
            overrun_r      <= overrun_s;
            rx_en_r        <= rx_en_s;
            tx_en_r        <= tx_en_s;
            busy_r         <= busy_s;
            rx_done_r      <= rx_done_s;
            tx_done_r      <= tx_done_s;
        end
    end

    // Grant latch plus guard and window counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= DIR_TX;
            grant_r      <= DIR_RX;
            win_len_r    <= 16'd0;
            guard_cnt_r  <= 8'd0;
            cnt_r        <= 16'd0;
        end else if (abort) begin
            guard_cnt_r  <= 8'd0;
            cnt_r        <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (granting_s) begin
                        grant_r      <= grant_s;
                        last_grant_r <= grant_s;
                        win_len_r    <= (grant_s == DIR_TX) ? ext_counter_value_TX
                                                            : ext_counter_value_RX;
                        guard_cnt_r  <= GUARD_LOAD;
                    end
                end
                GUARD: begin
                    guard_cnt_r <= guard_cnt_r - 8'd1;
                    if (guard_end_s) cnt_r <= win_len_r;
                end
                RX_WIN, TX_WIN: cnt_r <= cnt_r - 16'd1;
                default: cnt_r <= 16'd0;
            endcase
        end
    end

    assign rx_en   = rx_en_r;
    assign tx_en   = tx_en_r;
    assign busy    = busy_r;
    assign rx_done = rx_done_r;
    assign tx_done = tx_done_r;
    assign overrun = overrun_r;

endmodule

// File: doc/trx_sched.md
TRX_SCHED -- requirements
Module: trx_sched

Interface
REQ-001 Parameter GUARD_CYCLES, default 4: idle cycles inserted before every window; legal range 1..255.
REQ-002 Port clk  input  1  single clock; every register is clocked on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset.
REQ-004 Port ext_counter_value_RX  input  16  RX window length, in clk cycles.
REQ-005 Port ext_counter_flag_RX  input  1  level; a rising edge arms an RX window.
REQ-006 Port ext_counter_value_TX  input  16  TX window length, in clk cycles.
REQ-007 Port ext_counter_flag_TX  input  1  level; a rising edge arms a TX window.
REQ-008 Port abort  input  1  synchronous kill of all scheduling.
REQ-009 Port rx_en  output  1  RX window active.
REQ-010 Port tx_en  output  1  TX window active.
REQ-011 Port busy  output  1  state is not IDLE.
REQ-012 Port rx_done  output  1  one-cycle pulse when an RX window completes.
REQ-013 Port tx_done  output  1  one-cycle pulse when a TX window completes.
REQ-014 Port overrun  output  1  sticky; set when an arm arrives while the same direction is already pending.

Function
REQ-015 Flags shall be registered (flag_prev). A rising edge is flag & !flag_prev, and shall set the pending_RX or pending_TX bit on the next clock.
REQ-016 A falling edge or a steady level on a flag shall have no effect.
REQ-017 The FSM shall have exactly four states: IDLE, GUARD, RX_WIN, TX_WIN. All outputs shall be registered.
REQ-018 IDLE with any pending bit set shall go to GUARD on the next clock. At that transition the FSM shall:
- grant one direction;
- clear that direction's pending bit;
- latch that direction's 16-bit value into win_len;
- load guard_cnt with GUARD_CYCLES.
REQ-019 Arbitration: if only one direction is pending, it wins. If both are pending, the direction not granted last wins (round-robin). last_grant resets to TX, so RX wins the first tie.
REQ-020 GUARD shall last exactly GUARD_CYCLES cycles with rx_en = tx_en = 0, then:
- go to the granted WIN state with cnt = win_len, when win_len > 0;
- return to IDLE and pulse the granted done on that transition, when win_len = 0. No enable is asserted in this case.
REQ-021 In RX_WIN/TX_WIN the matching enable shall be high for exactly win_len consecutive cycles, and cnt shall decrement every cycle.
REQ-022 When cnt reaches 1: the enable shall drop next cycle, the matching done shall pulse for one cycle in that same cycle, and the state shall return to IDLE.
REQ-023 rx_en and tx_en shall never be high in the same cycle.
REQ-024 A value change on an input during GUARD or WIN shall not alter the current window, because the value was latched at grant.
REQ-025 An arm during an active window of the same direction shall queue one pending window; it shall be served after the current window, through GUARD.
REQ-026 An arm when that pending bit is already set shall be dropped and shall set overrun. overrun clears only on reset.
REQ-027 An arm in the same cycle that pending is cleared by a grant shall set pending again; it does not count as an overrun.
REQ-028 abort = 1 in any state:
- next clock: state = IDLE, both pending bits cleared, enables low, no done pulse;
- arms seen in the abort cycle are discarded;
- last_grant is unchanged.
REQ-029 win_len = 16'hFFFF shall produce 65535 enabled cycles, and cnt shall not wrap.
REQ-030 From an arm edge on an idle block, the enable shall rise after 2 + GUARD_CYCLES clocks: flag edge register, pending set/grant, then GUARD.

Reset
REQ-031 While rst = 0 the block shall be asynchronously forced to:
- state = IDLE;
- rx_en = tx_en = busy = rx_done = tx_done = overrun = 0;
- pending bits = 0, flag_prev = 0, cnt = win_len = guard_cnt = 0;
- last_grant = TX.
REQ-032 Reset asserted mid-window shall drop the enable immediately (asynchronously), with no done pulse.
REQ-033 After reset release, a flag that is already high shall count as a rising edge on the first clock, because flag_prev = 0.

Verification
REQ-034 RX alone: value_RX = 5, rise flag_RX -> rx_en high 5 cycles starting 6 clocks after the edge (GUARD_CYCLES = 4), then one rx_done pulse, busy low.
REQ-035 Tie: value_RX = 3 and value_TX = 2, both flags rise in the same cycle -> RX window of 3, GUARD of 4, TX window of 2, rx_done then tx_done; rx_en and tx_en never overlap.
REQ-036 Zero length: value_TX = 0, rise flag_TX -> 4 GUARD cycles, tx_done pulse, tx_en never high.
REQ-037 Overrun: during an RX window of 10, pulse flag_RX twice -> first pulse queues a second RX window of 10, second pulse sets overrun = 1 and is not served.
REQ-038 Abort: during a TX window of 100 with RX pending, abort at cycle 40 -> tx_en low next clock, no tx_done, RX never served, busy = 0.
REQ-039 Reset: rst low at TX window cycle 7 -> all outputs 0 immediately; after release with flag_TX still high -> a new TX window starts.
